mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_pkg.sv | 11 +
 rtl/ram_256x16.sv | 31 +++
 rtl/mem_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared defaults and loader FSM encoding for the mem_loader slice.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned WORD_W_DEF = 16;

  localparam logic [1:0] LOAD_HI = 2'd0;
  localparam logic [1:0] LOAD_LO = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

endpackage

// File: rtl/ram_256x16.sv
// Word memory: asynchronous read, one synchronous write port with low-byte-only select.
module ram_256x16
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_lo_only,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      if (i_lo_only) begin
        r_mem[i_wr_addr][7:0] <= i_wr_data[7:0];
      end else begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mem_loader.sv
// Byte-stream program loader in front of the processor memory; holds cpu_clr while loading.
// Optional load checksum enabled by defining LOAD_CHECKSUM_EN.
module mem_loader
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] adrs,
  input  logic              rw,
  input  logic [7:0]        dout,
  output logic [WORD_W-1:0] din,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_clr,
  output logic [7:0]        chk_sum
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [7:0]        r_hi;
  logic              r_cpu_clr;

  logic              w_lo_accept;
  logic              w_addr_max;
  logic              w_cpu_wr;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [WORD_W-1:0] w_wr_data;

  assign w_lo_accept = ld_valid && (r_state == LOAD_LO);
  assign w_addr_max  = &r_ld_addr;
  // Processor writes only land in RUN, so the loader is the sole writer while loading.
  assign w_cpu_wr    = (r_state == RUN) && !rw;
  assign w_we        = !clr && (w_lo_accept || w_cpu_wr);
  assign w_wr_addr   = w_lo_accept ? r_ld_addr : adrs;
  assign w_wr_data   = w_lo_accept ? WORD_W'({r_hi, ld_data}) : WORD_W'(dout);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= LOAD_HI;
      r_ld_addr <= '0;
      r_hi      <= 8'h00;
      r_cpu_clr <= 1'b1;
    end else begin
      r_cpu_clr <= (r_state != RUN);
      case (r_state)
        LOAD_HI: begin
          if (ld_valid) begin
            r_hi    <= ld_data;
            r_state <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (ld_valid) begin
            r_state <= (ld_last || w_addr_max) ? RUN : LOAD_HI;
            // Saturate at the top word so the address never wraps back to 0.
            if (!w_addr_max) begin
              r_ld_addr <= r_ld_addr + ADDR_W'(1);
            end
          end
        end
        RUN: begin
        end
        default: r_state <= LOAD_HI;
      endcase
    end
  end

  ram_256x16 #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .i_clk     (clk),
    .i_we      (w_we),
    .i_lo_only (!w_lo_accept),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (adrs),
    .o_rd_data (din)
  );

  assign ld_ready = (r_state != RUN);
  assign cpu_clr  = r_cpu_clr;

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] r_chk_sum;
  logic       w_accept;

  assign w_accept = ld_valid && (r_state != RUN);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_chk_sum <= 8'h00;
    end else if (w_accept) begin
      r_chk_sum <= r_chk_sum ^ ld_data;
    end
  end

  assign chk_sum = r_chk_sum;
`else
  assign chk_sum = 8'h00;
`endif

endmodule
